load_align_unit: RTL and testbench

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/load_pkg.sv | 26 ++
 rtl/load_extract.sv | 36 +++
 rtl/load_align_unit.sv | 118 +++++++++++
 tb/tb_load_align_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared states, size encodings and size helper for the load align unit
package load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_RESP
    } state_t;

    localparam logic [1:0] MEM_WORD  = 2'b00;
    localparam logic [1:0] MEM_HALF  = 2'b01;
    localparam logic [1:0] MEM_BYTE  = 2'b10;
    localparam logic [1:0] MEM_DWORD = 2'b11;

    // Doubleword encoding only means 8 bytes on a 64-bit datapath; otherwise it is a byte.
    function automatic logic [3:0] sizeBytes(input logic [1:0] mem_size, input int xlen);
        case (mem_size)
            MEM_WORD:  return 4'd4;
            MEM_HALF:  return 4'd2;
            MEM_DWORD: return (xlen == 64) ? 4'd8 : 4'd1;
            default:   return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - byte extraction from two bus beats plus sign/zero extension
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              beat0,
    input  logic [XLEN-1:0]              beat1,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [1:0]                   mem_size,
    input  logic                         is_signed,
    output logic [XLEN-1:0]              data
);

    localparam int OFFW = $clog2(XLEN/8);
    localparam int IW   = $clog2(2*XLEN);

    logic [2*XLEN-1:0] shifted;
    logic [OFFW+2:0]   shamt;
    logic [6:0]        nbits;
    logic [IW-1:0]     sign_idx;
    logic              fill;

    always_comb begin
        shamt    = {offset, 3'b000};
        shifted  = {beat1, beat0} >> shamt;
        nbits    = {sizeBytes(mem_size, XLEN), 3'b000};
        sign_idx = IW'(nbits - 7'd1);
        fill     = is_signed & shifted[sign_idx];
        data     = '0;
        for (int i = 0; i < XLEN; i++) begin
            data[i] = (i < int'(nbits)) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load unit issuing one or two aligned bus reads and aligning the result
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit SPLIT_MISALIGNED = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_reqValid,
    output logic            o_reqReady,
    input  logic [XLEN-1:0] i_addr,
    input  logic [1:0]      i_memSize,
    input  logic            i_isLoadSigned,
    output logic            o_busReq,
    input  logic            i_busGnt,
    output logic [XLEN-1:0] o_busAddr,
    input  logic            i_busRvalid,
    input  logic [XLEN-1:0] i_busRdata,
    output logic            o_rspValid,
    input  logic            i_rspReady,
    output logic [XLEN-1:0] o_readDataExt,
    output logic            o_misaligned
);

    localparam int BYTES = XLEN/8;
    localparam int OFFW  = $clog2(BYTES);

    state_t          state, state_nxt;
    logic [XLEN-1:0] addr_q, beat0_q, beat1_q, aligned, ext;
    logic [1:0]      size_q;
    logic            signed_q, pend_q, mis_q;
    logic            cross_in, cross_q, capture0, capture1;

    assign aligned  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign cross_in = (int'(i_addr[OFFW-1:0]) + int'(sizeBytes(i_memSize, XLEN))) > BYTES;
    assign cross_q  = (int'(addr_q[OFFW-1:0]) + int'(sizeBytes(size_q, XLEN))) > BYTES;

    load_extract #(.XLEN(XLEN)) u_extract (
        .beat0     (beat0_q),
        .beat1     (beat1_q),
        .offset    (addr_q[OFFW-1:0]),
        .mem_size  (size_q),
        .is_signed (signed_q),
        .data      (ext)
    );

    always_comb begin
        state_nxt     = state;
        o_reqReady    = 1'b0;
        o_busReq      = 1'b0;
        o_busAddr     = '0;
        o_rspValid    = 1'b0;
        o_readDataExt = '0;
        o_misaligned  = 1'b0;
        capture0      = 1'b0;
        capture1      = 1'b0;
        case (state)
            ST_IDLE: begin
                o_reqReady = 1'b1;
                if (i_reqValid) begin
                    state_nxt = (!SPLIT_MISALIGNED && cross_in) ? ST_RESP : ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                o_busAddr = aligned;
                o_busReq  = !pend_q;
                if (pend_q && i_busRvalid) begin
                    capture0  = 1'b1;
                    state_nxt = cross_q ? ST_BEAT1 : ST_RESP;
                end
            end
            ST_BEAT1: begin
                o_busAddr = aligned + XLEN'(BYTES);
                o_busReq  = !pend_q;
                if (pend_q && i_busRvalid) begin
                    capture1  = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                o_rspValid    = 1'b1;
                o_misaligned  = mis_q;
                o_readDataExt = mis_q ? '0 : ext;
                if (i_rspReady) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // pend_q marks a granted read whose data has not returned; stray rvalid is ignored without it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            mis_q    <= 1'b0;
            pend_q   <= 1'b0;
            beat0_q  <= '0;
            beat1_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && i_reqValid) begin
                addr_q   <= i_addr;
                size_q   <= i_memSize;
                signed_q <= i_isLoadSigned;
                mis_q    <= !SPLIT_MISALIGNED && cross_in;
                beat1_q  <= '0;
            end
            if (o_busReq && i_busGnt) pend_q <= 1'b1;
            if (capture0 || capture1) pend_q <= 1'b0;
            if (capture0) beat0_q <= i_busRdata;
            if (capture1) beat1_q <= i_busRdata;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - directed self-checking bench for load_align_unit
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  mem_size = '0;
    logic        is_signed = 1'b0;
    logic [31:0] rdata = '0;

    logic        req_valid = 1'b0, gnt = 1'b0, rvalid = 1'b0, rsp_ready = 1'b0;
    logic        req_ready, bus_req, rsp_valid, misaligned;
    logic [31:0] bus_addr, rdata_ext;

    logic        req_valid2 = 1'b0, gnt2 = 1'b0, rvalid2 = 1'b0, rsp_ready2 = 1'b0;
    logic        req_ready2, bus_req2, rsp_valid2, misaligned2;
    logic [31:0] bus_addr2, rdata_ext2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_align_unit #(.XLEN(32), .SPLIT_MISALIGNED(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_reqValid(req_valid), .o_reqReady(req_ready),
        .i_addr(addr), .i_memSize(mem_size), .i_isLoadSigned(is_signed),
        .o_busReq(bus_req), .i_busGnt(gnt), .o_busAddr(bus_addr),
        .i_busRvalid(rvalid), .i_busRdata(rdata),
        .o_rspValid(rsp_valid), .i_rspReady(rsp_ready),
        .o_readDataExt(rdata_ext), .o_misaligned(misaligned)
    );

    load_align_unit #(.XLEN(32), .SPLIT_MISALIGNED(0)) dut_nosplit (
        .i_clk(clk), .i_rst_n(rst_n), .i_reqValid(req_valid2), .o_reqReady(req_ready2),
        .i_addr(addr), .i_memSize(mem_size), .i_isLoadSigned(is_signed),
        .o_busReq(bus_req2), .i_busGnt(gnt2), .o_busAddr(bus_addr2),
        .i_busRvalid(rvalid2), .i_busRdata(rdata),
        .o_rspValid(rsp_valid2), .i_rspReady(rsp_ready2),
        .o_readDataExt(rdata_ext2), .o_misaligned(misaligned2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " reqReady"}, 32'(req_ready), 32'd1);
        check({tag, " busReq"},   32'(bus_req),   32'd0);
        check({tag, " busAddr"},  bus_addr,       32'd0);
        check({tag, " rspValid"}, 32'(rsp_valid), 32'd0);
        check({tag, " data"},     rdata_ext,      32'd0);
        check({tag, " mis"},      32'(misaligned), 32'd0);
    endtask

    // one bus beat: request visible, grant for one cycle, data one cycle later
    task automatic bus_beat(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
        check({tag, " busReq"},  32'(bus_req), 32'd1);
        check({tag, " busAddr"}, bus_addr, exp_addr);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rvalid = 1'b1;
        rdata = word;
        step();
        rvalid = 1'b0;
        rdata = 32'hDEAD_BEEF;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic sgn, input logic two_beats,
                        input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] exp);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        addr = a; mem_size = sz; is_signed = sgn; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        bus_beat({tag, " b0"}, {a[31:2], 2'b00}, w0);
        if (two_beats) bus_beat({tag, " b1"}, {a[31:2], 2'b00} + 32'd4, w1);
        check({tag, " rspValid"}, 32'(rsp_valid), 32'd1);
        check({tag, " data"}, rdata_ext, exp);
        check({tag, " mis"}, 32'(misaligned), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, " done rspValid"}, 32'(rsp_valid), 32'd0);
        check({tag, " done ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #3;
        check_idle("reset");
        step();
        rst_n = 1'b1;
        step();
        check_idle("post reset");

        // stray read data in IDLE must not create a response
        rvalid = 1'b1; rdata = 32'h1234_5678;
        step();
        rvalid = 1'b0;
        check_idle("stray rvalid");

        load("half s 0x102", 32'h102, 2'b01, 1'b1, 1'b0, 32'h8080_1234, 32'h0, 32'hFFFF_8080);
        load("byte u 0x101", 32'h101, 2'b10, 1'b0, 1'b0, 32'h0000_8080, 32'h0, 32'h0000_0080);
        load("byte s 0x101", 32'h101, 2'b10, 1'b1, 1'b0, 32'h0000_8080, 32'h0, 32'hFFFF_FF80);
        load("word 0x103",   32'h103, 2'b00, 1'b0, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44AA);
        load("half u 0x101", 32'h101, 2'b01, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 32'h0000_3456);
        load("half u 0x103", 32'h103, 2'b01, 1'b0, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0000_44AA);
        load("word 0x200",   32'h200, 2'b00, 1'b0, 1'b0, 32'h89AB_CDEF, 32'h0, 32'h89AB_CDEF);
        load("size11 s",     32'h302, 2'b11, 1'b1, 1'b0, 32'h00FE_0000, 32'h0, 32'hFFFF_FFFE);

        // grant held off, then response held off
        addr = 32'h406; mem_size = 2'b01; is_signed = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall busReq", 32'(bus_req), 32'd1);
            check("stall busAddr", bus_addr, 32'h404);
            step();
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        check("pend busReq", 32'(bus_req), 32'd0);
        step();
        rvalid = 1'b1; rdata = 32'hC3D4_0000;
        step();
        rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("hold rspValid", 32'(rsp_valid), 32'd1);
            check("hold data", rdata_ext, 32'h0000_C3D4);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("hold accept data", rdata_ext, 32'h0000_C3D4);
        step();
        rsp_ready = 1'b0;
        check("single rsp", 32'(rsp_valid), 32'd0);
        step();
        check("single rsp later", 32'(rsp_valid), 32'd0);

        // reset in the middle of the second beat
        addr = 32'h103; mem_size = 2'b00; is_signed = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        bus_beat("rst b0", 32'h100, 32'hAABB_CCDD);
        check("rst in beat1 addr", bus_addr, 32'h104);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle("async reset");
        step();
        rst_n = 1'b1;
        rvalid = 1'b1; rdata = 32'h5555_5555;
        step();
        rvalid = 1'b0;
        check_idle("late rvalid");
        load("after reset", 32'h103, 2'b00, 1'b0, 1'b1, 32'h0102_0304, 32'h0506_0708, 32'h0607_0801);

        // no-split variant flags the crossing word immediately
        addr = 32'h103; mem_size = 2'b00; is_signed = 1'b0; req_valid2 = 1'b1;
        #1;
        check("ns ready", 32'(req_ready2), 32'd1);
        step();
        req_valid2 = 1'b0;
        check("ns busReq", 32'(bus_req2), 32'd0);
        check("ns rspValid", 32'(rsp_valid2), 32'd1);
        check("ns mis", 32'(misaligned2), 32'd1);
        check("ns data", rdata_ext2, 32'd0);
        rsp_ready2 = 1'b1;
        step();
        rsp_ready2 = 1'b0;
        check("ns done", 32'(rsp_valid2), 32'd0);
        check("ns busReq after", 32'(bus_req2), 32'd0);
        check("ns addr", bus_addr2, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
